// File: rtl/esc_rx_classifier.sv
// esc_rx_classifier: multi-channel escalation receiver front-end.
// Registers each differential esc_p/esc_n pair, then classifies every pulse
// per channel as a ping (exactly one valid-high sample) or an escalation
// (EscDlyCycles or more valid-high samples), flagging integrity/protocol errors.
// Optional feature: define ESC_RX_CLASSIFIER_PING_CNT_EN to build the
// per-channel saturating ping counters; otherwise ping_cnt_o is tied to 0.
module esc_rx_classifier #(
  parameter int unsigned NumCh        = 4,
  parameter int unsigned EscDlyCycles = 2,
  parameter int unsigned CntW         = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumCh-1:0]      esc_p_i,
  input  logic [NumCh-1:0]      esc_n_i,
  input  logic                  clr_i,
  output logic [NumCh-1:0]      ping_o,
  output logic [NumCh-1:0]      esc_o,
  output logic [NumCh-1:0]      err_o,
  output logic [NumCh*CntW-1:0] ping_cnt_o
);

  localparam int unsigned LenW = $clog2(EscDlyCycles + 1);
  localparam logic [LenW-1:0] LenOne = LenW'(1);
  localparam logic [LenW-1:0] LenMax = LenW'(EscDlyCycles);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPulse = 2'd1;
  localparam logic [1:0] StEsc   = 2'd2;

  logic [NumCh-1:0]           r_p_q;
  logic [NumCh-1:0]           r_n_q;
  logic [NumCh-1:0][1:0]      r_state;
  logic [NumCh-1:0][LenW-1:0] r_len;
  logic [NumCh-1:0]           r_ping;
  logic [NumCh-1:0]           r_esc;
  logic [NumCh-1:0]           r_err;

  logic [NumCh-1:0]           w_hi;
  logic [NumCh-1:0]           w_lo;
  logic [NumCh-1:0]           w_bad;
  logic [NumCh-1:0][1:0]      w_state_d;
  logic [NumCh-1:0][LenW-1:0] w_len_d;
  logic [NumCh-1:0]           w_ping_d;
  logic [NumCh-1:0]           w_esc_d;
  logic [NumCh-1:0]           w_err_set;

  assign w_hi  = r_p_q & ~r_n_q;
  assign w_lo  = ~r_p_q & r_n_q;
  assign w_bad = ~(r_p_q ^ r_n_q);

  // Input stage: reset to the valid-low pair so no error follows reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_p_q <= '0;
      r_n_q <= '1;
    end else begin
      r_p_q <= esc_p_i;
      r_n_q <= esc_n_i;
    end
  end

  // Per-channel pulse classifier: next state, length, and output events.
  always_comb begin
    w_state_d = r_state;
    w_len_d   = r_len;
    w_ping_d  = '0;
    w_esc_d   = '0;
    w_err_set = '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      case (r_state[i])
        StIdle: begin
          if (w_hi[i]) begin
            w_state_d[i] = StPulse;
            w_len_d[i]   = LenOne;
          end else if (w_bad[i]) begin
            w_err_set[i] = 1'b1;
          end
        end
        StPulse: begin
          if (w_hi[i]) begin
            // len < EscDlyCycles here, so the increment cannot overflow.
            if (r_len[i] + LenOne == LenMax) begin
              w_state_d[i] = StEsc;
              w_len_d[i]   = LenMax;
              w_esc_d[i]   = 1'b1;
            end else begin
              w_len_d[i] = r_len[i] + LenOne;
            end
          end else begin
            if (w_lo[i] && (r_len[i] == LenOne)) begin
              w_ping_d[i] = 1'b1;
            end else begin
              w_err_set[i] = 1'b1;
            end
            w_state_d[i] = StIdle;
            w_len_d[i]   = '0;
          end
        end
        StEsc: begin
          if (w_hi[i]) begin
            w_esc_d[i] = 1'b1;
          end else begin
            w_err_set[i] = w_bad[i];
            w_state_d[i] = StIdle;
            w_len_d[i]   = '0;
          end
        end
        default: begin
          w_state_d[i] = StIdle;
          w_len_d[i]   = '0;
        end
      endcase
    end
  end

  // Classifier state and registered outputs; a new error beats clr_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= '0;
      r_len   <= '0;
      r_ping  <= '0;
      r_esc   <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_d;
      r_len   <= w_len_d;
      r_ping  <= w_ping_d;
      r_esc   <= w_esc_d;
      r_err   <= w_err_set | (r_err & ~{NumCh{clr_i}});
    end
  end

  assign ping_o = r_ping;
  assign esc_o  = r_esc;
  assign err_o  = r_err;

`ifdef ESC_RX_CLASSIFIER_PING_CNT_EN
  logic [NumCh-1:0][CntW-1:0] r_cnt;

  // Saturating ping counters; clr_i wins over a coincident ping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NumCh; i++) begin
        if (clr_i) begin
          r_cnt[i] <= '0;
        end else if (w_ping_d[i] && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  assign ping_cnt_o = r_cnt;
`else
  assign ping_cnt_o = '0;
`endif

endmodule

// File: tb/tb_esc_rx_classifier.sv
// tb_esc_rx_classifier: directed bench for esc_rx_classifier.
// Instance u_dut_a: NumCh=4, EscDlyCycles=2, CntW=2.
// Instance u_dut_b: NumCh=2, EscDlyCycles=4, CntW=2.
// Expected counter values follow ESC_RX_CLASSIFIER_PING_CNT_EN.
module tb_esc_rx_classifier;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [3:0] p_a, n_a;
  logic [3:0] ping_a, esc_a, err_a;
  logic [7:0] cnt_a;
  logic [1:0] p_b, n_b;
  logic [1:0] ping_b, esc_b, err_b;
  logic [3:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  esc_rx_classifier #(.NumCh(4), .EscDlyCycles(2), .CntW(2)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .esc_p_i(p_a), .esc_n_i(n_a), .clr_i(clr),
    .ping_o(ping_a), .esc_o(esc_a), .err_o(err_a), .ping_cnt_o(cnt_a)
  );

  esc_rx_classifier #(.NumCh(2), .EscDlyCycles(4), .CntW(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .esc_p_i(p_b), .esc_n_i(n_b), .clr_i(clr),
    .ping_o(ping_b), .esc_o(esc_b), .err_o(err_b), .ping_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input int ch, input logic pv, input logic nv);
    p_a[ch] = pv;
    n_a[ch] = nv;
  endtask

  task automatic drv_b(input int ch, input logic pv, input logic nv);
    p_b[ch] = pv;
    n_b[ch] = nv;
  endtask

  // Expected 2-bit counter value after k pings.
  function automatic logic [1:0] ec(input int k);
`ifdef ESC_RX_CLASSIFIER_PING_CNT_EN
    return (k > 3) ? 2'd3 : 2'(k);
`else
    return 2'd0;
`endif
  endfunction

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    p_a = 4'b0000; n_a = 4'b1111;
    p_b = 2'b00;   n_b = 2'b11;

    // Reset state
    tick();
    tick();
    check("rst_ping_a", 32'(ping_a), 32'h0);
    check("rst_esc_a",  32'(esc_a),  32'h0);
    check("rst_err_a",  32'(err_a),  32'h0);
    check("rst_cnt_a",  32'(cnt_a),  32'h0);
    check("rst_outs_b", 32'({ping_b, esc_b, err_b, cnt_b}), 32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_err_a", 32'(err_a), 32'h0);

    // Ping on ch0
    drv_a(0, 1'b1, 1'b0); tick();            // e
    drv_a(0, 1'b0, 1'b1); tick();            // e+1
    check("ping_e1", 32'(ping_a), 32'h0);
    tick();                                  // e+2
    check("ping_e2",     32'(ping_a), 32'h1);
    check("ping_no_esc", 32'(esc_a),  32'h0);
    check("ping_cnt0",   32'(cnt_a),  32'(ec(1)));
    tick();
    check("ping_1cyc", 32'(ping_a), 32'h0);

    // Escalation on ch1, 5 HI samples
    drv_a(1, 1'b1, 1'b0); tick();            // e
    check("esc_e0", 32'(esc_a), 32'h0);
    tick();                                  // e+1
    check("esc_e1", 32'(esc_a), 32'h0);
    tick();                                  // e+2
    check("esc_e2", 32'(esc_a), 32'h2);
    tick(); tick();                          // e+3, e+4
    drv_a(1, 1'b0, 1'b1); tick();            // e+5 captures LO
    check("esc_hold", 32'(esc_a), 32'h2);
    tick();
    check("esc_drop",    32'(esc_a),  32'h0);
    check("esc_no_ping", 32'(ping_a), 32'h0);
    check("esc_no_err",  32'(err_a),  32'h0);

    // Integrity error during escalation on ch2
    drv_a(2, 1'b1, 1'b0); tick(); tick(); tick();
    check("int_esc_on", 32'(esc_a), 32'h4);
    drv_a(2, 1'b1, 1'b1); tick();            // BAD captured
    check("int_pre", 32'(err_a), 32'h0);
    drv_a(2, 1'b0, 1'b1); tick();
    check("int_esc_off", 32'(esc_a), 32'h0);
    check("int_err",     32'(err_a), 32'h4);
    tick();
    check("int_sticky", 32'(err_a), 32'h4);
    clr = 1'b1; tick(); clr = 1'b0;
    check("int_clr", 32'(err_a), 32'h0);

    // Short pulse on B ch0 (EscDlyCycles=4)
    drv_b(0, 1'b1, 1'b0); tick(); tick();
    drv_b(0, 1'b0, 1'b1); tick();
    check("short_pre", 32'(err_b), 32'h0);
    tick();
    check("short_err",     32'(err_b),  32'h1);
    check("short_no_ping", 32'(ping_b), 32'h0);
    check("short_no_esc",  32'(esc_b),  32'h0);
    tick();
    check("short_sticky", 32'(err_b), 32'h1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("short_clr", 32'(err_b), 32'h0);

    // Escalation threshold on B ch1
    drv_b(1, 1'b1, 1'b0); tick(); tick(); tick(); tick();
    check("b_esc_e3", 32'(esc_b), 32'h0);
    tick();
    check("b_esc_e4", 32'(esc_b), 32'h2);
    drv_b(1, 1'b0, 1'b1); tick();
    check("b_esc_hold", 32'(esc_b), 32'h2);
    tick();
    check("b_esc_drop", 32'(esc_b), 32'h0);
    check("b_esc_err",  32'(err_b), 32'h0);

    // Saturating ping counter on A ch3
    for (int k = 1; k <= 5; k++) begin
      drv_a(3, 1'b1, 1'b0); tick();
      drv_a(3, 1'b0, 1'b1); tick(); tick();
      check($sformatf("cnt_ping_%0d", k), 32'(ping_a), 32'h8);
      check($sformatf("cnt_val_%0d", k), 32'(cnt_a[7:6]), 32'(ec(k)));
    end

    // Ping coincident with clear
    drv_a(3, 1'b1, 1'b0); tick();
    drv_a(3, 1'b0, 1'b1); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_ping", 32'(ping_a), 32'h8);
    check("clr_cnt",  32'(cnt_a),  32'h0);
    tick();
    check("clr_ping_end", 32'(ping_a), 32'h0);

    // Simultaneous pings on ch0 and ch1
    drv_a(0, 1'b1, 1'b0); drv_a(1, 1'b1, 1'b0); tick();
    drv_a(0, 1'b0, 1'b1); drv_a(1, 1'b0, 1'b1); tick(); tick();
    check("sim_ping", 32'(ping_a), 32'h3);
    check("sim_cnt",  32'(cnt_a),  32'({2'b00, 2'b00, ec(1), ec(1)}));

    // Reset in the middle of escalation on all channels
    p_a = 4'b1111; n_a = 4'b0000;
    p_b = 2'b11;   n_b = 2'b00;
    tick(); tick(); tick(); tick(); tick();
    check("rstm_esc_a", 32'(esc_a), 32'hf);
    check("rstm_esc_b", 32'(esc_b), 32'h3);
    #3 rst_n = 1'b0;
    #1;
    check("rstm_async_a", 32'({ping_a, esc_a, err_a, cnt_a}), 32'h0);
    check("rstm_async_b", 32'({ping_b, esc_b, err_b, cnt_b}), 32'h0);
    p_a = 4'b0000; n_a = 4'b1111;
    p_b = 2'b00;   n_b = 2'b11;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("rstm_after_a", 32'({ping_a, esc_a, err_a}), 32'h0);
    check("rstm_after_b", 32'({ping_b, esc_b, err_b}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
